uart_receiver: RTL and testbench

UART receive stage sitting directly downstream of the baud controller. It consumes the 16x oversampling strobe `sample_ENABLE` and deserialises one frame from the serial line `Rx_D`. A frame is 1 start bit, DATA_BITS data bits (LSB first), 1 even-parity bit and 1 stop bit. It presents the received byte with valid, parity-error and framing-error status to the system side.

---
 rtl/uart_receiver.sv | 85 ++++++++
 tb/tb_uart_receiver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART frame receiver (start, LSB-first data, even parity, stop) with 3-sample majority vote.
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_ENABLE,
  input  logic                 Rx_EN,
  input  logic                 Rx_D,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_VALID,
  output logic                 Rx_PERROR,
  output logic                 Rx_FERROR
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic rx_meta, rxs, v0, v1, par, perr, maj, wrap, decide, start_det, ok;
  logic [CW-1:0] cnt, t;
  logic [2:0] idx;
  logic [DATA_BITS-1:0] shreg, sh_next;
  // cnt holds the index of the last processed tick; t is the index of the current one
  always_comb begin
    t = (cnt == CW'(OVERSAMPLE - 1)) ? '0 : cnt + CW'(1);
    wrap = t == '0;
    decide = t == CW'(M + 1);
    maj = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
    sh_next = DATA_BITS'({maj, shreg} >> 1);
    start_det = sample_ENABLE && Rx_EN && !rxs;
    ok = !perr && maj;
    state_n = state;
    if (state != IDLE && !Rx_EN) state_n = IDLE;
    else if (sample_ENABLE)
      case (state)
        IDLE:    state_n = start_det ? START : IDLE;
        START:   state_n = (decide && maj) ? IDLE : wrap ? DATA : START;
        DATA:    state_n = (wrap && idx == 3'(DATA_BITS - 1)) ? PARITY : DATA;
        PARITY:  state_n = wrap ? STOP : PARITY;
        STOP:    state_n = decide ? IDLE : STOP;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {rx_meta, rxs} <= 2'b11;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      {v0, v1, par, perr} <= '0;
      Rx_DATA <= '0;
      {Rx_VALID, Rx_PERROR, Rx_FERROR} <= '0;
    end else begin
      {rx_meta, rxs} <= {Rx_D, rx_meta};
      if (sample_ENABLE && Rx_EN && state != IDLE) begin
        cnt <= t;
        if (t == CW'(M - 1)) v0 <= rxs;
        if (t == CW'(M)) v1 <= rxs;
        if (state == START && wrap) begin
          idx <= '0;
          par <= 1'b0;
        end
        if (state == DATA && decide) begin
          shreg <= sh_next;
          par <= par ^ maj;
        end
        if (state == DATA && wrap) idx <= idx + 3'd1;
        if (state == PARITY && decide) perr <= par ^ maj;
        // stop is judged mid-bit so a following start edge can be caught early
        if (state == STOP && decide) begin
          Rx_FERROR <= !maj;
          Rx_PERROR <= perr;
          Rx_VALID <= ok;
          Rx_DATA <= ok ? shreg : Rx_DATA;
        end
      end else if (state == IDLE && start_det) begin
        cnt <= '0;
        {Rx_VALID, Rx_PERROR, Rx_FERROR} <= '0;
      end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed-frame bench for uart_receiver with one sample_ENABLE tick every 4 clk.
module tb_uart_receiver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_ENABLE = 1'b0;
  logic Rx_EN = 1'b1;
  logic Rx_D = 1'b1;
  logic [7:0] Rx_DATA;
  logic Rx_VALID, Rx_PERROR, Rx_FERROR;
  int n_vec = 0;
  int n_err = 0;

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk),
    .reset(reset),
    .sample_ENABLE(sample_ENABLE),
    .Rx_EN(Rx_EN),
    .Rx_D(Rx_D),
    .Rx_DATA(Rx_DATA),
    .Rx_VALID(Rx_VALID),
    .Rx_PERROR(Rx_PERROR),
    .Rx_FERROR(Rx_FERROR)
  );

  always #5 clk = ~clk;

  // each tick is a 4-clk slot; returns on the negedge just after the tick's posedge
  task automatic tick(input int n);
    repeat (n) begin
      repeat (3) @(negedge clk);
      sample_ENABLE = 1'b1;
      @(negedge clk);
      sample_ENABLE = 1'b0;
    end
  endtask

  // drives start, data, parity and the first 9 ticks of stop; the next tick is the stop decision
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int bad);
    Rx_D = 1'b0;
    tick(16);
    for (int b = 0; b < 8; b++) begin
      Rx_D = d[b];
      if (b == bad) begin
        tick(7);
        Rx_D = ~d[b];
        tick(1);
        Rx_D = d[b];
        tick(8);
      end else tick(16);
    end
    Rx_D = p;
    tick(16);
    Rx_D = stop;
    tick(9);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_state: v/pe/fe/data=%b/%b/%b/%h want 0/0/0/00", Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
    end
    reset = 1'b0;
    tick(20);
    n_vec++;
    if ({Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA} !== 11'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: v/pe/fe/data=%b/%b/%b/%h want 0/0/0/00", Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
    end
  endtask

  task automatic test_nominal();
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    n_vec++;
    if ({Rx_VALID, Rx_DATA} !== {1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL nominal_early: v/data=%b/%h want 0/00 before stop decision", Rx_VALID, Rx_DATA);
    end
    tick(1);
    n_vec++;
    if ({Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA} !== {3'b100, 8'hA5}) begin
      n_err++;
      $display("FAIL nominal_a5: v/pe/fe/data=%b/%b/%b/%h want 1/0/0/a5", Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
    end
    tick(10);
  endtask

  task automatic test_parity_error();
    send_frame(8'h37, 1'b0, 1'b1, -1);
    tick(1);
    n_vec++;
    if ({Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA} !== {3'b010, 8'hA5}) begin
      n_err++;
      $display("FAIL parity_error: v/pe/fe/data=%b/%b/%b/%h want 0/1/0/a5", Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
    end
    tick(10);
  endtask

  task automatic test_framing_glitch();
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    tick(1);
    Rx_D = 1'b1;
    n_vec++;
    if ({Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA} !== {3'b001, 8'hA5}) begin
      n_err++;
      $display("FAIL framing_error: v/pe/fe/data=%b/%b/%b/%h want 0/0/1/a5", Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
    end
    tick(5);
    Rx_D = 1'b0;
    tick(1);
    n_vec++;
    if (Rx_FERROR !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_detect_clears: fe=%b want 0", Rx_FERROR);
    end
    tick(2);
    Rx_D = 1'b1;
    tick(30);
    n_vec++;
    if ({Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA} !== {3'b000, 8'hA5}) begin
      n_err++;
      $display("FAIL glitch_reject: v/pe/fe/data=%b/%b/%b/%h want 0/0/0/a5", Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
    end
  endtask

  task automatic test_majority();
    send_frame(8'h0F, 1'b0, 1'b1, 2);
    tick(1);
    n_vec++;
    if ({Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA} !== {3'b100, 8'h0F}) begin
      n_err++;
      $display("FAIL majority_vote: v/pe/fe/data=%b/%b/%b/%h want 1/0/0/0f", Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
    end
    tick(10);
  endtask

  task automatic test_enable_abort();
    logic [7:0] d;
    d = 8'h55;
    Rx_D = 1'b0;
    tick(16);
    for (int b = 0; b < 3; b++) begin
      Rx_D = d[b];
      tick(16);
    end
    Rx_D = d[3];
    tick(4);
    Rx_EN = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA} !== {3'b000, 8'h0F}) begin
      n_err++;
      $display("FAIL abort_outputs: v/pe/fe/data=%b/%b/%b/%h want 0/0/0/0f", Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
    end
    Rx_EN = 1'b1;
    Rx_D = 1'b1;
    tick(200);
    n_vec++;
    if ({Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA} !== {3'b000, 8'h0F}) begin
      n_err++;
      $display("FAIL abort_dropped: v/pe/fe/data=%b/%b/%b/%h want 0/0/0/0f", Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b0, 1'b1, -1);
    tick(1);
    n_vec++;
    if ({Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA} !== {3'b100, 8'h00}) begin
      n_err++;
      $display("FAIL b2b_first: v/pe/fe/data=%b/%b/%b/%h want 1/0/0/00", Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
    end
    send_frame(8'hFF, 1'b0, 1'b1, -1);
    tick(1);
    n_vec++;
    if ({Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA} !== {3'b100, 8'hFF}) begin
      n_err++;
      $display("FAIL b2b_second: v/pe/fe/data=%b/%b/%b/%h want 1/0/0/ff", Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
    end
    tick(10);
  endtask

  task automatic test_reset_midframe();
    Rx_D = 1'b0;
    tick(16);
    Rx_D = 1'b1;
    tick(16);
    Rx_D = 1'b0;
    tick(16);
    Rx_D = 1'b1;
    tick(16);
    Rx_D = 1'b0;
    tick(5);
    reset = 1'b1;
    #1;
    n_vec++;
    if ({Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA} !== 11'b0) begin
      n_err++;
      $display("FAIL async_reset_midframe: v/pe/fe/data=%b/%b/%b/%h want 0/0/0/00", Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
    end
    Rx_D = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(200);
    n_vec++;
    if ({Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA} !== 11'b0) begin
      n_err++;
      $display("FAIL idle_after_midframe_reset: v/pe/fe/data=%b/%b/%b/%h want 0/0/0/00", Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_parity_error();
    test_framing_glitch();
    test_majority();
    test_enable_abort();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
